// File: rtl/sb_io_pkg.sv
// Field encodings and PIN_TYPE extract helpers for the programmable I/O cell.
// Pure definitions: no latency and no flow control.
package sb_io_pkg;

    localparam logic [1:0] OE_NEVER      = 2'b00;
    localparam logic [1:0] OE_ALWAYS     = 2'b01;
    localparam logic [1:0] OE_COMB       = 2'b10;
    localparam logic [1:0] OE_REG        = 2'b11;

    localparam logic [1:0] DOUT_DDR      = 2'b00;
    localparam logic [1:0] DOUT_REG      = 2'b01;
    localparam logic [1:0] DOUT_COMB     = 2'b10;
    localparam logic [1:0] DOUT_REG_INV  = 2'b11;

    localparam logic [1:0] DIN_REG       = 2'b00;
    localparam logic [1:0] DIN_COMB      = 2'b01;
    localparam logic [1:0] DIN_REG_LATCH = 2'b10;
    localparam logic [1:0] DIN_LATCH     = 2'b11;

    function automatic logic [1:0] pin_oe_mode(input logic [5:0] pin_type);
        return pin_type[5:4];
    endfunction

    function automatic logic [1:0] pin_out_mode(input logic [5:0] pin_type);
        return pin_type[3:2];
    endfunction

    function automatic logic [1:0] pin_in_mode(input logic [5:0] pin_type);
        return pin_type[1:0];
    endfunction

endpackage

// File: rtl/sb_io_ff.sv
// One-bit flop on a selectable clock edge with synchronous reset and enable.
// Latency one edge; holds its value while en_i is low, reset has priority.
module sb_io_ff #(
    parameter logic NEG_EDGE = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic d_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (en_i) begin
            q_d = d_i;
        end
    end

    generate
        if (NEG_EDGE) begin : g_neg
            always_ff @(negedge clk_i) begin
                if (rst_i) q_q <= 1'b0;
                else       q_q <= q_d;
            end
        end else begin : g_pos
            always_ff @(posedge clk_i) begin
                if (rst_i) q_q <= 1'b0;
                else       q_q <= q_d;
            end
        end
    endgenerate

    assign q_o = q_q;

endmodule

// File: rtl/sb_io_cell.sv
// Single-bit programmable pad: per-path registered/combinational output, OE and input.
// Registered paths add one primary edge of latency; CLOCK_ENABLE=0 freezes every register.
module sb_io_cell
    import sb_io_pkg::*;
#(
    parameter logic [5:0] PIN_TYPE    = 6'b000000,
    parameter logic       PULLUP      = 1'b0,
    parameter logic       NEG_TRIGGER = 1'b0
) (
    input  logic clk,
    input  logic tb_rst,
    inout  wire  PACKAGE_PIN,
    input  logic CLOCK_ENABLE,
    input  logic LATCH_INPUT_VALUE,
    input  logic OUTPUT_ENABLE,
    input  logic D_OUT_0,
    input  logic D_OUT_1,
    output logic D_IN_0,
    output logic D_IN_1
);

    localparam logic [1:0] OE_MODE  = pin_oe_mode(PIN_TYPE);
    localparam logic [1:0] OUT_MODE = pin_out_mode(PIN_TYPE);
    localparam logic [1:0] IN_MODE  = pin_in_mode(PIN_TYPE);

    logic dout0_q, dout1_q, oe_q, din0_q, din1_q, din_hold_q;
    logic pad_in, in_en, post_primary, dout_sel, oe_eff;

    // Registered input modes with latch control stop sampling while latched.
    assign in_en = CLOCK_ENABLE && !((IN_MODE == DIN_REG_LATCH) && LATCH_INPUT_VALUE);

    sb_io_ff #(.NEG_EDGE(NEG_TRIGGER)) u_dout0 (
        .clk_i(clk), .rst_i(tb_rst), .en_i(CLOCK_ENABLE), .d_i(D_OUT_0), .q_o(dout0_q));
    sb_io_ff #(.NEG_EDGE(!NEG_TRIGGER)) u_dout1 (
        .clk_i(clk), .rst_i(tb_rst), .en_i(CLOCK_ENABLE), .d_i(D_OUT_1), .q_o(dout1_q));
    sb_io_ff #(.NEG_EDGE(NEG_TRIGGER)) u_oe (
        .clk_i(clk), .rst_i(tb_rst), .en_i(CLOCK_ENABLE), .d_i(OUTPUT_ENABLE), .q_o(oe_q));
    sb_io_ff #(.NEG_EDGE(NEG_TRIGGER)) u_din0 (
        .clk_i(clk), .rst_i(tb_rst), .en_i(in_en), .d_i(pad_in), .q_o(din0_q));
    sb_io_ff #(.NEG_EDGE(!NEG_TRIGGER)) u_din1 (
        .clk_i(clk), .rst_i(tb_rst), .en_i(in_en), .d_i(pad_in), .q_o(din1_q));

    // High while clk sits in the half-period that follows the primary edge.
    assign post_primary = clk ^ NEG_TRIGGER;

    always_comb begin
        dout_sel = 1'b0;
        case (OUT_MODE)
            DOUT_COMB:    dout_sel = D_OUT_0;
            DOUT_REG:     dout_sel = dout0_q;
            DOUT_REG_INV: dout_sel = ~dout0_q;
            DOUT_DDR:     dout_sel = post_primary ? dout0_q : dout1_q;
            default:      dout_sel = 1'b0;
        endcase
    end

    always_comb begin
        oe_eff = 1'b0;
        case (OE_MODE)
            OE_NEVER:  oe_eff = 1'b0;
            OE_ALWAYS: oe_eff = 1'b1;
            OE_COMB:   oe_eff = OUTPUT_ENABLE;
            OE_REG:    oe_eff = oe_q;
            default:   oe_eff = 1'b0;
        endcase
    end

    assign PACKAGE_PIN = oe_eff ? dout_sel : 1'bz;

    generate
        if (PULLUP) begin : g_pullup
            pullup u_pullup (PACKAGE_PIN);
        end
    endgenerate

    assign pad_in = ((PULLUP == 1'b1) && (PACKAGE_PIN !== 1'b0)) ? 1'b1 : PACKAGE_PIN;

    // Transparent while unlatched; freezes the last pad value when latched.
    always_latch begin
        if (!LATCH_INPUT_VALUE) begin
            din_hold_q <= pad_in;
        end
    end

    always_comb begin
        D_IN_0 = 1'b0;
        D_IN_1 = 1'b0;
        case (IN_MODE)
            DIN_COMB: D_IN_0 = pad_in;
            DIN_LATCH: D_IN_0 = LATCH_INPUT_VALUE ? din_hold_q : pad_in;
            DIN_REG, DIN_REG_LATCH: begin
                D_IN_0 = din0_q;
                D_IN_1 = din1_q;
            end
            default: D_IN_0 = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_sb_io_cell.sv
// Scoreboarded bench for sb_io_cell across tristate, registered, inverted, DDR and latch configurations.
module tb_sb_io_cell;

    logic clk = 1'b0;
    logic tb_rst, ce, latch, oe, d0, d1;
    logic ext_en, ext_val;

    wire pad_tri, pad_pu, pad_reg, pad_rego, pad_lat, pad_inv, pad_ddr;
    logic din_tri, din_pu, din_reg, din_rego, din_lat, din_inv, din_ddr;
    logic din1_tri, din1_pu, din1_reg, din1_rego, din1_lat, din1_inv, din1_ddr;

    assign pad_tri = ext_en ? ext_val : 1'bz;
    assign pad_pu  = ext_en ? ext_val : 1'bz;

    always #5 clk = ~clk;

    sb_io_cell #(.PIN_TYPE(6'b101001), .PULLUP(1'b0)) u_tri (
        .clk(clk), .tb_rst(tb_rst), .PACKAGE_PIN(pad_tri), .CLOCK_ENABLE(ce),
        .LATCH_INPUT_VALUE(latch), .OUTPUT_ENABLE(oe), .D_OUT_0(d0), .D_OUT_1(d1),
        .D_IN_0(din_tri), .D_IN_1(din1_tri));
    sb_io_cell #(.PIN_TYPE(6'b101001), .PULLUP(1'b1)) u_tri_pu (
        .clk(clk), .tb_rst(tb_rst), .PACKAGE_PIN(pad_pu), .CLOCK_ENABLE(ce),
        .LATCH_INPUT_VALUE(latch), .OUTPUT_ENABLE(oe), .D_OUT_0(d0), .D_OUT_1(d1),
        .D_IN_0(din_pu), .D_IN_1(din1_pu));
    sb_io_cell #(.PIN_TYPE(6'b010100)) u_reg (
        .clk(clk), .tb_rst(tb_rst), .PACKAGE_PIN(pad_reg), .CLOCK_ENABLE(ce),
        .LATCH_INPUT_VALUE(latch), .OUTPUT_ENABLE(oe), .D_OUT_0(d0), .D_OUT_1(d1),
        .D_IN_0(din_reg), .D_IN_1(din1_reg));
    sb_io_cell #(.PIN_TYPE(6'b110100)) u_rego (
        .clk(clk), .tb_rst(tb_rst), .PACKAGE_PIN(pad_rego), .CLOCK_ENABLE(ce),
        .LATCH_INPUT_VALUE(latch), .OUTPUT_ENABLE(oe), .D_OUT_0(d0), .D_OUT_1(d1),
        .D_IN_0(din_rego), .D_IN_1(din1_rego));
    sb_io_cell #(.PIN_TYPE(6'b010011)) u_lat (
        .clk(clk), .tb_rst(tb_rst), .PACKAGE_PIN(pad_lat), .CLOCK_ENABLE(ce),
        .LATCH_INPUT_VALUE(latch), .OUTPUT_ENABLE(oe), .D_OUT_0(d0), .D_OUT_1(d1),
        .D_IN_0(din_lat), .D_IN_1(din1_lat));
    sb_io_cell #(.PIN_TYPE(6'b011101)) u_inv (
        .clk(clk), .tb_rst(tb_rst), .PACKAGE_PIN(pad_inv), .CLOCK_ENABLE(ce),
        .LATCH_INPUT_VALUE(latch), .OUTPUT_ENABLE(oe), .D_OUT_0(d0), .D_OUT_1(d1),
        .D_IN_0(din_inv), .D_IN_1(din1_inv));
    sb_io_cell #(.PIN_TYPE(6'b010000)) u_ddr (
        .clk(clk), .tb_rst(tb_rst), .PACKAGE_PIN(pad_ddr), .CLOCK_ENABLE(ce),
        .LATCH_INPUT_VALUE(latch), .OUTPUT_ENABLE(oe), .D_OUT_0(d0), .D_OUT_1(d1),
        .D_IN_0(din_ddr), .D_IN_1(din1_ddr));

    int n_checks = 0;
    int n_fail   = 0;
    logic  exp_q[$];
    string tag_q[$];

    task automatic check_val(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exp(input string tag, input logic v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic pop_check(input logic obs);
        string t;
        logic  e;
        if (exp_q.size() == 0) begin
            check_val("sb_underflow", 1'b1, 1'b0);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check_val(t, obs, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_low();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        tb_rst = 1'b1; ce = 1'b1; latch = 1'b0; oe = 1'b0;
        d0 = 1'b0; d1 = 1'b0; ext_en = 1'b0; ext_val = 1'b0;
        repeat (2) step();

        // Reset state of registered paths
        push_exp("rst_din_reg", 1'b0);   pop_check(din_reg);
        push_exp("rst_pad_reg", 1'b0);   pop_check(pad_reg);
        push_exp("rst_pad_inv", 1'b1);   pop_check(pad_inv);
        push_exp("rst_din1_ddr", 1'b0);  pop_check(din1_ddr);
        push_exp("rst_din_ddr", 1'b0);   pop_check(din_ddr);
        push_exp("rst_din1_lat", 1'b0);  pop_check(din1_lat);
        tb_rst = 1'b0;

        // Combinational tristate output with loopback
        oe = 1'b1; d0 = 1'b1; #1;
        push_exp("t1_pad_hi", 1'b1);     pop_check(pad_tri);
        push_exp("t1_din_hi", 1'b1);     pop_check(din_tri);
        d0 = 1'b0; #1;
        push_exp("t1_pad_lo", 1'b0);     pop_check(pad_tri);
        push_exp("t1_din_lo", 1'b0);     pop_check(din_tri);

        // External driver with output disabled
        oe = 1'b0; ext_en = 1'b1; ext_val = 1'b0; #1;
        push_exp("t2_din_ext0", 1'b0);   pop_check(din_tri);
        ext_val = 1'b1; #1;
        push_exp("t2_din_ext1", 1'b1);   pop_check(din_tri);
        ext_val = 1'b0; #1;
        push_exp("t3_pu_driven0", 1'b0); pop_check(din_pu);
        ext_en = 1'b0; #1;

        // Floating pad: pull-up reads 1, no pull-up does not read 1
        push_exp("t3_pu_float", 1'b1);   pop_check(din_pu);
        push_exp("t3_nopu_not1", 1'b0);  pop_check(din_tri === 1'b1);

        // Registered output and input
        step(); d0 = 1'b0; step();
        push_exp("t4_pad_init", 1'b0);   pop_check(pad_reg);
        #3; d0 = 1'b1; #1;
        push_exp("t4_pad_midcyc", 1'b0); pop_check(pad_reg);
        step();
        push_exp("t4_pad_edge1", 1'b1);  pop_check(pad_reg);
        push_exp("t4_din_edge1", 1'b0);  pop_check(din_reg);
        push_exp("t4_inv_edge1", 1'b0);  pop_check(pad_inv);
        step();
        push_exp("t4_din_edge2", 1'b1);  pop_check(din_reg);
        ce = 1'b0; d0 = 1'b0;
        repeat (2) step();
        push_exp("t4_pad_ce_hold", 1'b1); pop_check(pad_reg);
        push_exp("t4_din_ce_hold", 1'b1); pop_check(din_reg);
        ce = 1'b1;

        // Registered OE, then reset mid-operation
        oe = 1'b1; d0 = 1'b1; step();
        push_exp("t5_pad_on", 1'b1);     pop_check(pad_rego);
        step();
        push_exp("t5_din_on", 1'b1);     pop_check(din_rego);
        tb_rst = 1'b1; step();
        push_exp("t5_rst_din", 1'b0);    pop_check(din_rego);
        push_exp("t5_rst_pad_not1", 1'b0); pop_check(pad_rego === 1'b1);
        push_exp("t5_rst_pad_reg0", 1'b0); pop_check(pad_reg);
        push_exp("t5_rst_comb_tri", 1'b1); pop_check(pad_tri);
        tb_rst = 1'b0; step();
        push_exp("t5_pad_after", 1'b1);  pop_check(pad_rego);
        ce = 1'b0; tb_rst = 1'b1; step();
        push_exp("t5_rst_over_ce", 1'b0); pop_check(pad_rego === 1'b1);
        ce = 1'b1; tb_rst = 1'b0;

        // Combinational input with latch hold
        d0 = 1'b0; step();
        push_exp("t6_din_pre", 1'b0);    pop_check(din_lat);
        latch = 1'b1; d0 = 1'b1; step();
        push_exp("t6_pad_tog", 1'b1);    pop_check(pad_lat);
        push_exp("t6_din_held", 1'b0);   pop_check(din_lat);
        d0 = 1'b0; step(); d0 = 1'b1; step();
        push_exp("t6_din_held2", 1'b0);  pop_check(din_lat);
        latch = 1'b0; #1;
        push_exp("t6_din_release", 1'b1); pop_check(din_lat);
        d0 = 1'b0; step();
        push_exp("t6_din_track", 1'b0);  pop_check(din_lat);
        push_exp("t6_din1_zero", 1'b0);  pop_check(din1_lat);

        // DDR output: primary register in high phase, secondary in low phase
        step_low(); d0 = 1'b1; d1 = 1'b0;
        step();
        push_exp("ddr_hi_a", 1'b1);      pop_check(pad_ddr);
        step_low();
        push_exp("ddr_lo_a", 1'b0);      pop_check(pad_ddr);
        d0 = 1'b0; d1 = 1'b1;
        step();
        push_exp("ddr_hi_b", 1'b0);      pop_check(pad_ddr);
        step_low();
        push_exp("ddr_lo_b", 1'b1);      pop_check(pad_ddr);

        check_val("sb_drain", exp_q.size() == 0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
